// File: rtl/mont_axil_slave.sv
// mont_axil_slave: AXI4-Lite responder register file for the Montgomery IP.
// Holds DATA0..3, CTRL, STATUS, RESULT and CLEAR, and drives the core's
// start/busy/done/result handshake.
// Optional macro AXI_SLVERR_EN: when defined, writes to RO registers and
// unaligned accesses return SLVERR. When undefined, every access is OKAY.
module mont_axil_slave #(
    parameter int          C_DATA_WIDTH   = 32,
    parameter int          C_ADDR_WIDTH   = 5,
    parameter logic [31:0] C_RESULT_RESET = 32'h0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                ARPROT,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [C_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic                      core_start,
    input  logic                      core_busy,
    input  logic                      core_done,
    input  logic [C_DATA_WIDTH-1:0]   core_result
);

    localparam int         STRB_W      = C_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge of new write data into an existing word.
    function automatic logic [C_DATA_WIDTH-1:0] merge_bytes(
        input logic [C_DATA_WIDTH-1:0] old_word,
        input logic [C_DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]       strb
    );
        logic [C_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Write channel state
    logic                    awready_q, awready_d;
    logic                    aw_held_q, aw_held_d;
    logic [C_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                    wready_q,  wready_d;
    logic                    w_held_q,  w_held_d;
    logic [C_DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]       w_strb_q,  w_strb_d;
    logic                    bvalid_q,  bvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    // Read channel state
    logic                    arready_q, arready_d;
    logic                    rvalid_q,  rvalid_d;
    logic [C_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]              rresp_q,   rresp_d;
    // Register file and core bridge
    logic [C_DATA_WIDTH-1:0] data_q [4];
    logic [C_DATA_WIDTH-1:0] data_d [4];
    logic                    irq_en_q,  irq_en_d;
    logic                    done_q,    done_d;
    logic [C_DATA_WIDTH-1:0] result_q,  result_d;
    logic                    start_q,   start_d;

    logic                    commit_s;
    logic                    clear_s;
    logic                    wr_err_s;
    logic                    rd_err_s;
    logic [2:0]              wr_idx_s;
    logic [2:0]              rd_idx_s;
    logic [C_DATA_WIDTH-1:0] rd_word_s;
    logic                    unused_ok_s;

    assign wr_idx_s    = aw_addr_q[4:2];
    assign rd_idx_s    = ARADDR[4:2];
    assign commit_s    = aw_held_q && w_held_q && !bvalid_q;
    assign unused_ok_s = &{1'b0, AWPROT, ARPROT, aw_addr_q[1:0], ARADDR[1:0]};

    assign AWREADY    = awready_q;
    assign WREADY     = wready_q;
    assign BVALID     = bvalid_q;
    assign BRESP      = bresp_q;
    assign ARREADY    = arready_q;
    assign RVALID     = rvalid_q;
    assign RDATA      = rdata_q;
    assign RRESP      = rresp_q;
    assign core_start = start_q;

    // Access error classification; only active in the SLVERR build.
    always_comb begin
`ifdef AXI_SLVERR_EN
        wr_err_s = (aw_addr_q[1:0] != 2'b00) || (wr_idx_s == 3'd5) || (wr_idx_s == 3'd6);
        rd_err_s = (ARADDR[1:0] != 2'b00);
`else
        wr_err_s = 1'b0;
        rd_err_s = 1'b0;
`endif
    end

    // Read mux over current register contents (old value on same-cycle write).
    always_comb begin
        rd_word_s = {C_DATA_WIDTH{1'b0}};
        case (rd_idx_s)
            3'd0:    rd_word_s = data_q[0];
            3'd1:    rd_word_s = data_q[1];
            3'd2:    rd_word_s = data_q[2];
            3'd3:    rd_word_s = data_q[3];
            3'd4:    rd_word_s = {{(C_DATA_WIDTH-2){1'b0}}, irq_en_q, 1'b0};
            3'd5:    rd_word_s = {{(C_DATA_WIDTH-2){1'b0}}, done_q, core_busy};
            3'd6:    rd_word_s = result_q;
            3'd7:    rd_word_s = {C_DATA_WIDTH{1'b0}};
            default: rd_word_s = {C_DATA_WIDTH{1'b0}};
        endcase
    end

    // Next-state logic for both AXI channels, the register file and the core bridge.
    always_comb begin
        awready_d = 1'b0;
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        wready_d  = 1'b0;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        data_d    = data_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        result_d  = result_q;
        start_d   = 1'b0;
        clear_s   = 1'b0;

        // READY pulses are one cycle wide and never offered while a response is pending.
        if (!awready_q && AWVALID && !aw_held_q && !bvalid_q) begin
            awready_d = 1'b1;
        end else begin
            awready_d = 1'b0;
        end
        if (!wready_q && WVALID && !w_held_q && !bvalid_q) begin
            wready_d = 1'b1;
        end else begin
            wready_d = 1'b0;
        end

        if (awready_q && AWVALID) begin
            aw_held_d = 1'b1;
            aw_addr_d = AWADDR;
        end else begin
            aw_addr_d = aw_addr_q;
        end
        if (wready_q && WVALID) begin
            w_held_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end else begin
            w_data_d = w_data_q;
        end

        if (commit_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err_s ? RESP_SLVERR : RESP_OKAY;
            if (!wr_err_s) begin
                case (wr_idx_s)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        data_d[wr_idx_s[1:0]] = merge_bytes(data_q[wr_idx_s[1:0]], w_data_q, w_strb_q);
                    end
                    3'd4: begin
                        if (w_strb_q[0]) begin
                            irq_en_d = w_data_q[1];
                            start_d  = w_data_q[0] && !core_busy;
                        end else begin
                            irq_en_d = irq_en_q;
                        end
                    end
                    3'd7:    clear_s = 1'b1;
                    default: clear_s = 1'b0;
                endcase
            end else begin
                clear_s = 1'b0;
            end
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        // A done pulse takes priority over a simultaneous CLEAR.
        if (core_done) begin
            result_d = core_result;
            done_d   = 1'b1;
        end else if (clear_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (!arready_q && ARVALID && !rvalid_q) begin
            arready_d = 1'b1;
        end else begin
            arready_d = 1'b0;
        end
        if (arready_q && ARVALID) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err_s ? {C_DATA_WIDTH{1'b0}} : rd_word_s;
            rresp_d  = rd_err_s ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State register with synchronous reset; reset drops any in-flight transaction.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            aw_held_q <= 1'b0;
            aw_addr_q <= {C_ADDR_WIDTH{1'b0}};
            wready_q  <= 1'b0;
            w_held_q  <= 1'b0;
            w_data_q  <= {C_DATA_WIDTH{1'b0}};
            w_strb_q  <= {STRB_W{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {C_DATA_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= {C_DATA_WIDTH{1'b0}};
            end
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= C_RESULT_RESET[C_DATA_WIDTH-1:0];
            start_q   <= 1'b0;
        end else begin
            awready_q <= awready_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            wready_q  <= wready_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            data_q    <= data_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            result_q  <= result_d;
            start_q   <= start_d;
        end
    end

endmodule

// File: tb/tb_mont_axil_slave.sv
// Self-checking bench for mont_axil_slave: scenario tasks push expected
// responses into queues and pop them when the DUT answers.
module tb_mont_axil_slave;

`ifdef AXI_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif
    localparam logic [1:0] ERR_RESP = SLV ? 2'b10 : 2'b00;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [4:0]  AWADDR = 5'h0;
    logic [2:0]  AWPROT = 3'h0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = 32'h0;
    logic [3:0]  WSTRB = 4'h0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [4:0]  ARADDR = 5'h0;
    logic [2:0]  ARPROT = 3'h0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        core_start;
    logic        core_busy = 1'b0;
    logic        core_done = 1'b0;
    logic [31:0] core_result = 32'h0;

    int tests = 0;
    int fails = 0;
    int start_total = 0;

    logic [31:0] exp_data_q [$];
    logic [1:0]  exp_resp_q [$];

    mont_axil_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .core_start(core_start), .core_busy(core_busy),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 ACLK = ~ACLK;

    // Count cycles in which core_start is high.
    always @(negedge ACLK) begin
        if (core_start === 1'b1) start_total++;
    end

    // Complete whatever AW/W is being presented, then take the B response.
    task automatic finish_write(output logic [1:0] resp);
        int n;
        bit aw_hs;
        bit w_hs;
        n = 0;
        while ((AWVALID || WVALID) && n < 40) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge ACLK);
            if (aw_hs) AWVALID = 1'b0;
            if (w_hs) WVALID = 1'b0;
            n++;
        end
        while (!BVALID && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        if (!BVALID) begin
            tests++; fails++;
            $display("FAIL write_timeout addr=%h no BVALID within 40 cycles", AWADDR);
            AWVALID = 1'b0; WVALID = 1'b0;
            resp = 2'bxx;
        end else begin
            resp = BRESP;
            BREADY = 1'b1;
            @(negedge ACLK);
            BREADY = 1'b0;
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        @(negedge ACLK);
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1;
        finish_write(resp);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!ARREADY) begin
            tests++; fails++;
            $display("FAIL read_timeout addr=%h no ARREADY within 20 cycles", a);
            ARVALID = 1'b0;
            d = 32'bx; resp = 2'bxx;
        end else begin
            @(negedge ACLK);
            ARVALID = 1'b0;
            n = 0;
            while (!RVALID && n < 20) begin
                @(negedge ACLK);
                n++;
            end
            d = RDATA; resp = RRESP;
            RREADY = 1'b1;
            @(negedge ACLK);
            RREADY = 1'b0;
        end
    endtask

    task automatic pulse_done(input logic [31:0] r);
        @(negedge ACLK);
        core_result = r; core_done = 1'b1;
        @(negedge ACLK);
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, ed;
        logic [1:0]  rr, er;
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        tests++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, core_start} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {AWREADY, WREADY, BVALID, ARREADY, RVALID, core_start});
        end
        tests++;
        if ({BRESP, RRESP} !== 4'b0 || RDATA !== 32'h0) begin
            fails++;
            $display("FAIL reset_resp got=%b/%h exp=0000/00000000", {BRESP, RRESP}, RDATA);
        end
        ARESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_data_q.push_back(32'h0); exp_resp_q.push_back(2'b00);
            axi_read(5'(i * 4), rd, rr);
            ed = exp_data_q.pop_front(); er = exp_resp_q.pop_front();
            tests++;
            if (rd !== ed || rr !== er) begin
                fails++;
                $display("FAIL reset_read idx=%0d got=%h/%b exp=%h/%b", i, rd, rr, ed, er);
            end
        end
    endtask

    task automatic test_data_rw();
        logic [31:0] vals [4];
        logic [31:0] rd, ed;
        logic [1:0]  rr, er, br;
        vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001;
        vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) begin
            exp_resp_q.push_back(2'b00);
            axi_write(5'(i * 4), vals[i], 4'hF, br);
            er = exp_resp_q.pop_front();
            tests++;
            if (br !== er) begin
                fails++;
                $display("FAIL data_bresp idx=%0d got=%b exp=%b", i, br, er);
            end
            exp_data_q.push_back(vals[i]); exp_resp_q.push_back(2'b00);
            axi_read(5'(i * 4), rd, rr);
            ed = exp_data_q.pop_front(); er = exp_resp_q.pop_front();
            tests++;
            if (rd !== ed || rr !== er) begin
                fails++;
                $display("FAIL data_read idx=%0d got=%h/%b exp=%h/%b", i, rd, rr, ed, er);
            end
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd, ed;
        logic [1:0]  rr, er, br;
        axi_write(5'h00, 32'h0, 4'hF, br);
        axi_write(5'h00, 32'hFFFFFFFF, 4'b0101, br);
        exp_data_q.push_back(32'h00FF00FF); exp_resp_q.push_back(2'b00);
        axi_read(5'h00, rd, rr);
        ed = exp_data_q.pop_front(); er = exp_resp_q.pop_front();
        tests++;
        if (rd !== ed || rr !== er) begin
            fails++;
            $display("FAIL strobe_read got=%h/%b exp=%h/%b", rd, rr, ed, er);
        end
    endtask

    task automatic test_aw_before_w();
        logic [31:0] rd, ed;
        logic [1:0]  rr, er, br;
        bit hs;
        int n;
        @(negedge ACLK);
        AWADDR = 5'h04; AWVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hs = AWVALID && AWREADY;
            @(negedge ACLK);
            if (hs) AWVALID = 1'b0;
        end
        tests++;
        if (BVALID !== 1'b0) begin
            fails++;
            $display("FAIL aw_only_bvalid got=%b exp=0", BVALID);
        end
        WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1;
        n = 0;
        while (WVALID && n < 20) begin
            hs = WVALID && WREADY;
            @(negedge ACLK);
            if (hs) WVALID = 1'b0;
            n++;
        end
        while (!BVALID && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        exp_resp_q.push_back(2'b00);
        er = exp_resp_q.pop_front();
        // Hold BREADY low for 4 cycles while a second write is offered.
        AWADDR = 5'h08; WDATA = 32'h55667788; AWVALID = 1'b1; WVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            tests++;
            if (BVALID !== 1'b1 || BRESP !== er || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                fails++;
                $display("FAIL b_hold cyc=%0d got bv=%b br=%b awr=%b wr=%b exp 1/%b/0/0",
                         i, BVALID, BRESP, AWREADY, WREADY, er);
            end
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        exp_resp_q.push_back(2'b00);
        finish_write(br);
        er = exp_resp_q.pop_front();
        tests++;
        if (br !== er) begin
            fails++;
            $display("FAIL second_bresp got=%b exp=%b", br, er);
        end
        exp_data_q.push_back(32'h11223344); exp_data_q.push_back(32'h55667788);
        for (int i = 0; i < 2; i++) begin
            axi_read(5'(4 + i * 4), rd, rr);
            ed = exp_data_q.pop_front();
            tests++;
            if (rd !== ed || rr !== 2'b00) begin
                fails++;
                $display("FAIL aw_w_read idx=%0d got=%h/%b exp=%h/00", i + 1, rd, rr, ed);
            end
        end
    endtask

    task automatic test_core_start_done();
        logic [31:0] rd, ed;
        logic [1:0]  rr, br;
        logic [4:0]  addrs [4];
        int s0;
        core_busy = 1'b0;
        s0 = start_total;
        axi_write(5'h10, 32'h1, 4'hF, br);
        repeat (3) @(negedge ACLK);
        tests++;
        if (start_total - s0 !== 1 || core_start !== 1'b0) begin
            fails++;
            $display("FAIL start_pulse got=%0d cycles exp=1", start_total - s0);
        end
        pulse_done(32'h12345678);
        addrs[0] = 5'h10; exp_data_q.push_back(32'h0);
        addrs[1] = 5'h14; exp_data_q.push_back(32'h2);
        addrs[2] = 5'h18; exp_data_q.push_back(32'h12345678);
        for (int i = 0; i < 3; i++) begin
            axi_read(addrs[i], rd, rr);
            ed = exp_data_q.pop_front();
            tests++;
            if (rd !== ed || rr !== 2'b00) begin
                fails++;
                $display("FAIL core_read addr=%h got=%h/%b exp=%h/00", addrs[i], rd, rr, ed);
            end
        end
        axi_write(5'h1C, 32'hDEADBEEF, 4'hF, br);
        exp_data_q.push_back(32'h0);
        axi_read(5'h14, rd, rr);
        ed = exp_data_q.pop_front();
        tests++;
        if (rd !== ed) begin
            fails++;
            $display("FAIL clear_status got=%h exp=%h", rd, ed);
        end
    endtask

    task automatic test_busy();
        logic [31:0] rd, ed;
        logic [1:0]  rr, br;
        int s0;
        @(negedge ACLK);
        core_busy = 1'b1;
        s0 = start_total;
        axi_write(5'h10, 32'h3, 4'hF, br);
        repeat (3) @(negedge ACLK);
        tests++;
        if (start_total - s0 !== 0) begin
            fails++;
            $display("FAIL busy_start got=%0d cycles exp=0", start_total - s0);
        end
        exp_data_q.push_back(32'h1);
        axi_read(5'h14, rd, rr);
        ed = exp_data_q.pop_front();
        tests++;
        if (rd !== ed) begin
            fails++;
            $display("FAIL busy_status got=%h exp=%h", rd, ed);
        end
        exp_data_q.push_back(32'h2);
        axi_read(5'h10, rd, rr);
        ed = exp_data_q.pop_front();
        tests++;
        if (rd !== ed) begin
            fails++;
            $display("FAIL busy_irq_en got=%h exp=%h", rd, ed);
        end
        core_busy = 1'b0;
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] rd, ed;
        logic [1:0]  rr, br;
        int n;
        @(negedge ACLK);
        AWADDR = 5'h00; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        tests++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
            fails++;
            $display("FAIL midreset_chan got bv=%b awr=%b wr=%b exp 0/0/0", BVALID, AWREADY, WREADY);
        end
        for (int i = 0; i < 4; i++) begin
            exp_data_q.push_back(32'h0);
            axi_read(5'(i * 4), rd, rr);
            ed = exp_data_q.pop_front();
            tests++;
            if (rd !== ed) begin
                fails++;
                $display("FAIL midreset_data idx=%0d got=%h exp=%h", i, rd, ed);
            end
        end
        axi_write(5'h04, 32'hCAFEF00D, 4'hF, br);
        exp_data_q.push_back(32'hCAFEF00D);
        axi_read(5'h04, rd, rr);
        ed = exp_data_q.pop_front();
        tests++;
        if (rd !== ed || br !== 2'b00) begin
            fails++;
            $display("FAIL post_reset_write got=%h/%b exp=%h/00", rd, br, ed);
        end
    endtask

    task automatic test_ro_and_unaligned();
        logic [31:0] rd, ed;
        logic [1:0]  rr, er, br;
        pulse_done(32'hA5A50F0F);
        exp_resp_q.push_back(ERR_RESP);
        axi_write(5'h18, 32'hFFFFFFFF, 4'hF, br);
        er = exp_resp_q.pop_front();
        tests++;
        if (br !== er) begin
            fails++;
            $display("FAIL ro_bresp got=%b exp=%b", br, er);
        end
        exp_data_q.push_back(32'hA5A50F0F); exp_resp_q.push_back(2'b00);
        axi_read(5'h18, rd, rr);
        ed = exp_data_q.pop_front(); er = exp_resp_q.pop_front();
        tests++;
        if (rd !== ed || rr !== er) begin
            fails++;
            $display("FAIL ro_result got=%h/%b exp=%h/%b", rd, rr, ed, er);
        end
        exp_resp_q.push_back(ERR_RESP);
        axi_write(5'h05, 32'h0BADF00D, 4'hF, br);
        er = exp_resp_q.pop_front();
        tests++;
        if (br !== er) begin
            fails++;
            $display("FAIL unaligned_bresp got=%b exp=%b", br, er);
        end
        exp_data_q.push_back(SLV ? 32'h0 : 32'h0BADF00D); exp_resp_q.push_back(ERR_RESP);
        axi_read(5'h05, rd, rr);
        ed = exp_data_q.pop_front(); er = exp_resp_q.pop_front();
        tests++;
        if (rd !== ed || rr !== er) begin
            fails++;
            $display("FAIL unaligned_read got=%h/%b exp=%h/%b", rd, rr, ed, er);
        end
        exp_data_q.push_back(SLV ? 32'hCAFEF00D : 32'h0BADF00D);
        axi_read(5'h04, rd, rr);
        ed = exp_data_q.pop_front();
        tests++;
        if (rd !== ed || rr !== 2'b00) begin
            fails++;
            $display("FAIL unaligned_effect got=%h/%b exp=%h/00", rd, rr, ed);
        end
    endtask

    initial begin
        test_reset();
        test_data_rw();
        test_strobe();
        test_aw_before_w();
        test_core_start_done();
        test_busy();
        test_reset_midwrite();
        test_ro_and_unaligned();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
